// File: rtl/alien_fleet.sv
// 6x6 alien formation: origin, alive mask, motion on the enable tick, and a
// two-stage laser hit pipeline with one-kill-per-shot lockout.
module alien_fleet #(
  parameter int COLS         = 6,
  parameter int ROWS         = 6,
  parameter int X_INIT       = 64,
  parameter int Y_INIT       = 48,
  parameter int ALIEN_W      = 32,
  parameter int ALIEN_H      = 16,
  parameter int PITCH_X      = 48,
  parameter int PITCH_Y      = 32,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 16,
  parameter int SCREEN_W     = 640,
  parameter int BOTTOM_LIMIT = 440
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           motion,
  input  logic                 respawn,
  input  logic                 laserActive,
  input  logic [9:0]           xLaser,
  input  logic [9:0]           yLaser,
  output logic [9:0]           xAlien,
  output logic [9:0]           yAlien,
  output logic [COLS*ROWS-1:0] alive,
  output logic                 killingAlien,
  output logic                 canLeft,
  output logic                 canRight,
  output logic                 cleared,
  output logic                 invaded
);

  localparam int NA = COLS * ROWS;
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int IW = $clog2(NA + COLS + 1);

  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [NA-1:0] alive_q, alive_d;
  logic          kill_q, kill_d;
  logic          canl_q, canl_d, canr_q, canr_d;
  logic          clr_q, clr_d, inv_q, inv_d;
  logic          lock_q, lock_d;
  logic          vld_p1_q, vld_p1_d;
  logic          inbox_p1_q;
  logic [IW-1:0] idx_p1_q;

  logic [10:0]   dx_p0, dy_p0, xbase_p0, ybase_p0;
  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  logic [IW-1:0] ioff_p0, idx_p0;
  logic          inbox_p0;

  logic [NA-1:0]   hit_mask_p2;
  logic [COLS-1:0] col_live;
  logic [ROWS-1:0] row_live;
  logic [10:0]     lc_off, rc_off, rb_off;

  function automatic logic [9:0] sat_down(input logic [9:0] y);
    logic [10:0] s;
    s = {1'b0, y} + 11'(STEP_Y);
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  // Stage 0 -> 1: locate the laser tip in the formation grid without dividers
  always_comb begin
    dx_p0    = {1'b0, xLaser} - {1'b0, x_q};
    dy_p0    = {1'b0, yLaser} - {1'b0, y_q};
    col_p0   = '0;
    xbase_p0 = '0;
    row_p0   = '0;
    ybase_p0 = '0;
    ioff_p0  = '0;
    for (int k = 1; k <= COLS; k++) begin
      if (dx_p0 >= 11'(k * PITCH_X)) begin
        col_p0   = CW'(k);
        xbase_p0 = 11'(k * PITCH_X);
      end
    end
    for (int k = 1; k <= ROWS; k++) begin
      if (dy_p0 >= 11'(k * PITCH_Y)) begin
        row_p0   = RW'(k);
        ybase_p0 = 11'(k * PITCH_Y);
        ioff_p0  = IW'(k * COLS);
      end
    end
    inbox_p0 = !dx_p0[10] && !dy_p0[10] &&
               ((dx_p0 - xbase_p0) < 11'(ALIEN_W)) &&
               ((dy_p0 - ybase_p0) < 11'(ALIEN_H)) &&
               (col_p0 < CW'(COLS)) && (row_p0 < RW'(ROWS));
    idx_p0   = ioff_p0 + IW'(col_p0);
    vld_p1_d = laserActive && !lock_q;
  end

  // Stage 1 -> 2: kill decision against the live mask
  always_comb begin
    hit_mask_p2 = inbox_p1_q ? ({{(NA-1){1'b0}}, 1'b1} << idx_p1_q) : '0;
    kill_d      = vld_p1_q && !lock_q && (|(hit_mask_p2 & alive_q));
    alive_d     = kill_d ? (alive_q & ~hit_mask_p2) : alive_q;
    lock_d      = laserActive ? (lock_q || kill_d) : 1'b0;
  end

  always_comb begin
    col_live = '0;
    row_live = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_q[r*COLS+c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
      end
    end
    lc_off = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_live[c]) lc_off = 11'(c * PITCH_X);
    end
    rc_off = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_live[c]) rc_off = 11'(c * PITCH_X);
    end
    rb_off = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_live[r]) rb_off = 11'(r * PITCH_Y);
    end
    canl_d = (|col_live) && (({1'b0, x_q} + lc_off) >= 11'(STEP_X));
    canr_d = (|col_live) &&
             (({1'b0, x_q} + rc_off + 11'(ALIEN_W + STEP_X)) <= 11'(SCREEN_W));
    inv_d  = (|row_live) &&
             (({1'b0, y_q} + rb_off + 11'(ALIEN_H)) >= 11'(BOTTOM_LIMIT));
    clr_d  = ~|alive_q;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (enable && (|alive_q)) begin
      case (motion)
        3'b001:  if (canr_q) x_d = x_q + 10'(STEP_X);
        3'b010:  if (canl_q) x_d = x_q - 10'(STEP_X);
        3'b100:  y_d = sat_down(y_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || respawn) begin
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      alive_q  <= '1;
      kill_q   <= 1'b0;
      canl_q   <= 1'b1;
      canr_q   <= 1'b1;
      clr_q    <= 1'b0;
      inv_q    <= 1'b0;
      lock_q   <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      alive_q  <= alive_d;
      kill_q   <= kill_d;
      canl_q   <= canl_d;
      canr_q   <= canr_d;
      clr_q    <= clr_d;
      inv_q    <= inv_d;
      lock_q   <= lock_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    inbox_p1_q <= inbox_p0;
    idx_p1_q   <= idx_p0;
  end

  assign xAlien       = x_q;
  assign yAlien       = y_q;
  assign alive        = alive_q;
  assign killingAlien = kill_q;
  assign canLeft      = canl_q;
  assign canRight     = canr_q;
  assign cleared      = clr_q;
  assign invaded      = inv_q;

endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet: integer-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_alien_fleet;

  logic        clk, reset, enable, respawn, laserActive;
  logic [2:0]  motion;
  logic [9:0]  xLaser, yLaser;
  logic [9:0]  xAlien, yAlien;
  logic [35:0] alive;
  logic        killingAlien, canLeft, canRight, cleared, invaded;

  alien_fleet dut (
    .clk(clk), .reset(reset), .enable(enable), .motion(motion),
    .respawn(respawn), .laserActive(laserActive), .xLaser(xLaser),
    .yLaser(yLaser), .xAlien(xAlien), .yAlien(yAlien), .alive(alive),
    .killingAlien(killingAlien), .canLeft(canLeft), .canRight(canRight),
    .cleared(cleared), .invaded(invaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: origin/mask as plain integers, hits via / and %.
  int        m_x, m_y, m_p1idx;
  bit [35:0] m_alive;
  bit        m_kill, m_canL, m_canR, m_clr, m_inv, m_lock, m_p1v;
  bit        m_started = 0;
  int        any, lc, rc, rb, dx, dy, nx, ny, n_idx;
  bit        hit, n_canL, n_canR, n_clr, n_inv, n_lock, n_p1v;
  bit [35:0] n_alive;

  always @(posedge clk) begin
    m_started = 1;
    if (!reset || respawn) begin
      m_x = 64; m_y = 48; m_alive = '1; m_kill = 0; m_canL = 1; m_canR = 1;
      m_clr = 0; m_inv = 0; m_lock = 0; m_p1v = 0; m_p1idx = -1;
    end else begin
      any = 0; lc = 99; rc = -1; rb = -1;
      for (int i = 0; i < 36; i++) begin
        if (m_alive[i]) begin
          any = 1;
          if (i % 6 < lc) lc = i % 6;
          if (i % 6 > rc) rc = i % 6;
          if (i / 6 > rb) rb = i / 6;
        end
      end
      n_canL = any && (m_x + lc * 48 >= 4);
      n_canR = any && (m_x + rc * 48 + 32 + 4 <= 640);
      n_inv  = any && (m_y + rb * 32 + 16 >= 440);
      n_clr  = (m_alive == 0);

      hit = m_p1v && !m_lock && (m_p1idx >= 0) && m_alive[m_p1idx];
      n_alive = m_alive;
      if (hit) n_alive[m_p1idx] = 1'b0;
      n_lock = laserActive ? (m_lock || hit) : 1'b0;
      n_p1v  = laserActive && !m_lock;
      dx = int'(xLaser) - m_x;
      dy = int'(yLaser) - m_y;
      n_idx = -1;
      if (dx >= 0 && dy >= 0 && (dx % 48) < 32 && (dy % 32) < 16 &&
          (dx / 48) < 6 && (dy / 32) < 6)
        n_idx = (dy / 32) * 6 + (dx / 48);

      nx = m_x; ny = m_y;
      if (enable && m_alive != 0) begin
        if (motion == 3'b001 && m_canR) nx = m_x + 4;
        else if (motion == 3'b010 && m_canL) nx = m_x - 4;
        else if (motion == 3'b100) ny = (m_y + 16 > 1023) ? 1023 : m_y + 16;
      end

      m_x = nx; m_y = ny; m_alive = n_alive; m_kill = hit;
      m_canL = n_canL; m_canR = n_canR; m_clr = n_clr; m_inv = n_inv;
      m_lock = n_lock; m_p1v = n_p1v; m_p1idx = n_idx;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("xAlien",       64'(xAlien),       64'(m_x));
      chk("yAlien",       64'(yAlien),       64'(m_y));
      chk("alive",        64'(alive),        64'(m_alive));
      chk("killingAlien", 64'(killingAlien), 64'(m_kill));
      chk("canLeft",      64'(canLeft),      64'(m_canL));
      chk("canRight",     64'(canRight),     64'(m_canR));
      chk("cleared",      64'(cleared),      64'(m_clr));
      chk("invaded",      64'(invaded),      64'(m_inv));
    end
  end

  task automatic pulse_enable(input logic [2:0] mv, input int n);
    motion = mv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); enable = 1'b1;
      @(negedge clk); enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic shoot(input int x, input int y);
    @(negedge clk); xLaser = 10'(x); yLaser = 10'(y); laserActive = 1'b1;
    @(negedge clk); laserActive = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Checks a DUT value and the model's value against the same literal.
  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] mdl,
                     input logic [63:0] exp);
    chk({nm, "_dut"}, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  int cnt;

  initial begin
    reset = 1'b0; enable = 1'b0; respawn = 1'b0; laserActive = 1'b0;
    motion = 3'b000; xLaser = '0; yLaser = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lit("rst_x", 64'(xAlien), 64'(m_x), 64);
    lit("rst_y", 64'(yAlien), 64'(m_y), 48);
    lit("rst_alive", 64'(alive), 64'(m_alive), 64'h0F_FFFF_FFFF);
    lit("rst_canL", 64'(canLeft), 64'(m_canL), 1);
    lit("rst_canR", 64'(canRight), 64'(m_canR), 1);
    lit("rst_kill", 64'(killingAlien), 64'(m_kill), 0);
    lit("rst_clr", 64'(cleared), 64'(m_clr), 0);

    // Laser on alien (row 1, col 2): one pulse two cycles after the sample
    xLaser = 10'd170; yLaser = 10'd85; laserActive = 1'b1;
    @(negedge clk);
    lit("kill_lat1", 64'(killingAlien), 64'(m_kill), 0);
    @(negedge clk);
    lit("kill_lat2", 64'(killingAlien), 64'(m_kill), 1);
    cnt = 0;
    repeat (6) begin @(negedge clk); cnt += int'(killingAlien); end
    chk("kill_once", 64'(cnt), 0);
    lit("alive_bit8", 64'(alive), 64'(m_alive), 64'h0F_FFFF_FEFF);
    laserActive = 1'b0;
    repeat (2) @(negedge clk);

    // Gap between columns 0 and 1
    xLaser = 10'd99; yLaser = 10'd50; laserActive = 1'b1;
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(killingAlien); end
    chk("gap_nokill", 64'(cnt), 0);
    lit("gap_alive", 64'(alive), 64'(m_alive), 64'h0F_FFFF_FEFF);
    laserActive = 1'b0;

    @(negedge clk); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
    lit("resp1_alive", 64'(alive), 64'(m_alive), 64'h0F_FFFF_FFFF);

    pulse_enable(3'b001, 80);
    lit("right_stop_x", 64'(xAlien), 64'(m_x), 368);
    lit("right_stop_canR", 64'(canRight), 64'(m_canR), 0);
    pulse_enable(3'b010, 1);
    lit("left_x", 64'(xAlien), 64'(m_x), 364);
    pulse_enable(3'b011, 2);
    lit("illegal_hold_x", 64'(xAlien), 64'(m_x), 364);

    for (int r = 0; r < 6; r++) shoot(364 + 5 * 48 + 1, 48 + r * 32 + 1);
    lit("col5_alive", 64'(alive), 64'(m_alive), 64'h07_DF7D_F7DF);
    lit("col5_canR", 64'(canRight), 64'(m_canR), 1);
    pulse_enable(3'b001, 20);
    lit("col5_stop_x", 64'(xAlien), 64'(m_x), 416);
    lit("col5_stop_canR", 64'(canRight), 64'(m_canR), 0);

    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) shoot(416 + c * 48 + 1, 48 + r * 32 + 1);
    lit("clr_alive", 64'(alive), 64'(m_alive), 0);
    lit("clr_flag", 64'(cleared), 64'(m_clr), 1);
    lit("clr_canL", 64'(canLeft), 64'(m_canL), 0);
    lit("clr_canR", 64'(canRight), 64'(m_canR), 0);
    pulse_enable(3'b100, 2);
    pulse_enable(3'b010, 2);
    lit("frozen_x", 64'(xAlien), 64'(m_x), 416);
    lit("frozen_y", 64'(yAlien), 64'(m_y), 48);

    @(negedge clk); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
    lit("resp2_x", 64'(xAlien), 64'(m_x), 64);
    lit("resp2_alive", 64'(alive), 64'(m_alive), 64'h0F_FFFF_FFFF);
    lit("resp2_canR", 64'(canRight), 64'(m_canR), 1);
    lit("resp2_clr", 64'(cleared), 64'(m_clr), 0);

    pulse_enable(3'b100, 15);
    lit("down_y", 64'(yAlien), 64'(m_y), 288);
    lit("down_invaded", 64'(invaded), 64'(m_inv), 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
